// File: rtl/pf_result_checker_if.sv
// Reader/finder/status bundle between the pattern-finder vector reader, the finder
// under test and the result checker.
interface pf_result_checker_if #(
  parameter int MXADRB = 10,
  parameter int MXERRB = 16
);
  logic              start;
  logic [MXADRB-1:0] rd_adr;
  logic              rd_done;
  logic              increment;

  logic [7:0]        key_hs_expect_1st, key_hs_expect_2nd;
  logic [3:0]        pat_expect_1st,    pat_expect_2nd;
  logic [11:0]       ccode_expect_1st,  ccode_expect_2nd;

  logic [7:0]        key_hs_1st, key_hs_2nd;
  logic [3:0]        pat_1st,    pat_2nd;
  logic [11:0]       ccode_1st,  ccode_2nd;

  logic              busy;
  logic              done;
  logic              pass;
  logic [MXADRB:0]   vec_cnt;
  logic [MXERRB-1:0] err_cnt;
  logic [MXADRB-1:0] first_err_adr;
  logic              first_err_vld;

  modport master (
    output start, rd_adr, rd_done,
    output key_hs_expect_1st, key_hs_expect_2nd, pat_expect_1st, pat_expect_2nd,
    output ccode_expect_1st, ccode_expect_2nd,
    output key_hs_1st, key_hs_2nd, pat_1st, pat_2nd, ccode_1st, ccode_2nd,
    input  increment, busy, done, pass, vec_cnt, err_cnt, first_err_adr, first_err_vld
  );

  modport slave (
    input  start, rd_adr, rd_done,
    input  key_hs_expect_1st, key_hs_expect_2nd, pat_expect_1st, pat_expect_2nd,
    input  ccode_expect_1st, ccode_expect_2nd,
    input  key_hs_1st, key_hs_2nd, pat_1st, pat_2nd, ccode_1st, ccode_2nd,
    output increment, busy, done, pass, vec_cnt, err_cnt, first_err_adr, first_err_vld
  );
endinterface

// File: rtl/pf_result_checker.sv
// Paces the pattern-finder vector reader, waits out the finder latency, and scores
// the finder's 1st/2nd CLCT against the reader's expected values.

module pf_clct_cmp #(
  parameter int CLCT_W = 24
) (
  input  logic [CLCT_W-1:0] expect_v,
  input  logic [CLCT_W-1:0] found,
  input  logic              en,
  output logic              mismatch
);
  assign mismatch = en && (expect_v != found);
endmodule

module pf_result_checker #(
  parameter int MXADRB     = 10,
  parameter int PF_LATENCY = 4,
  parameter int MXERRB     = 16,
  parameter int CHECK_2ND  = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  pf_result_checker_if.slave bus
);
  localparam int NUM_CLCT = 2;

  typedef struct packed {
    logic [7:0]  key_hs;
    logic [3:0]  pat;
    logic [11:0] ccode;
  } clct_t;

  localparam int          CLCT_W = $bits(clct_t);
  localparam logic [3:0]  LAT    = 4'(PF_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  clct_t [NUM_CLCT-1:0] exp_c, act_c;
  logic  [NUM_CLCT-1:0] lane_en, lane_mis;
  logic                 mismatch;

  assign exp_c[0] = {bus.key_hs_expect_1st, bus.pat_expect_1st, bus.ccode_expect_1st};
  assign exp_c[1] = {bus.key_hs_expect_2nd, bus.pat_expect_2nd, bus.ccode_expect_2nd};
  assign act_c[0] = {bus.key_hs_1st, bus.pat_1st, bus.ccode_1st};
  assign act_c[1] = {bus.key_hs_2nd, bus.pat_2nd, bus.ccode_2nd};
  assign lane_en  = {(CHECK_2ND != 0), 1'b1};

  for (genvar i = 0; i < NUM_CLCT; i++) begin : g_lane
    pf_clct_cmp #(.CLCT_W(CLCT_W)) u_cmp (
      .expect_v (exp_c[i]),
      .found    (act_c[i]),
      .en       (lane_en[i]),
      .mismatch (lane_mis[i])
    );
  end

  assign mismatch = |lane_mis;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              increment, busy, done, pass;
  logic [MXADRB:0]   vec_cnt;
  logic [MXERRB-1:0] err_cnt, err_nxt;
  logic [MXADRB-1:0] first_err_adr;
  logic              first_err_vld;
  logic              last_adr;

  // Error count saturates at all-ones rather than wrapping back to a clean-looking value.
  assign err_nxt  = (mismatch && !(&err_cnt)) ? err_cnt + MXERRB'(1) : err_cnt;
  assign last_adr = &bus.rd_adr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      increment     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_adr <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          increment <= 1'b0;
          if (bus.start) begin
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_adr <= '0;
            first_err_vld <= 1'b0;
            if (bus.rd_done) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= LAT;
              busy     <= 1'b1;
            end
          end
        end

        // Increment is registered, so it is raised on the last wait clock to land in CHECK.
        S_WAIT: begin
          if (bus.rd_done) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end else if (wait_cnt == 4'd1) begin
            state     <= S_CHECK;
            increment <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_CHECK: begin
          increment <= 1'b0;
          if (bus.rd_done) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0);
          end else begin
            vec_cnt <= vec_cnt + 1'b1;
            err_cnt <= err_nxt;
            if (mismatch && !first_err_vld) begin
              first_err_adr <= bus.rd_adr;
              first_err_vld <= 1'b1;
            end
            if (last_adr) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              state    <= S_WAIT;
              wait_cnt <= LAT;
            end
          end
        end

        default: begin
          increment <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.increment     = increment;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.vec_cnt       = vec_cnt;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_adr = first_err_adr;
  assign bus.first_err_vld = first_err_vld;
endmodule

// File: tb/tb_pf_result_checker.sv
// Four checker configurations run in lockstep from shared vector tables; each has its
// own reader model, scoreboard queue and monitor.
module tb_pf_result_checker;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic rdr_clr = 1'b1;
  logic force_done = 1'b0;
  bit   mid_reset = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  logic [23:0] exp1 [8];
  logic [23:0] exp2 [8];
  logic [23:0] c1 [8];
  logic [23:0] c2 [8];

  typedef struct {
    bit is_done;
    int cyc;
    int vec;
    int err;
    int fadr;
    bit fvld;
    bit pass;
  } ev_t;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_inst
    localparam int ADRB = (k == 3) ? 2 : 3;
    localparam int LAT  = (k == 3) ? 1 : 4;
    localparam int ERRB = (k == 2) ? 2 : 16;
    localparam int C2   = (k == 1) ? 0 : 1;
    localparam int NV   = 1 << ADRB;
    localparam int SAT  = (1 << ERRB) - 1;

    pf_result_checker_if #(.MXADRB(ADRB), .MXERRB(ERRB)) bus ();

    pf_result_checker #(
      .MXADRB(ADRB), .PF_LATENCY(LAT), .MXERRB(ERRB), .CHECK_2ND(C2)
    ) u_dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
    );

    logic [ADRB-1:0] adr;
    logic            dn;
    logic [2:0]      ai;

    assign ai          = 3'(adr);
    assign bus.start   = start;
    assign bus.rd_adr  = adr;
    assign bus.rd_done = dn;
    assign {bus.key_hs_expect_1st, bus.pat_expect_1st, bus.ccode_expect_1st} = exp1[ai];
    assign {bus.key_hs_expect_2nd, bus.pat_expect_2nd, bus.ccode_expect_2nd} = exp2[ai];
    assign {bus.key_hs_1st, bus.pat_1st, bus.ccode_1st} = exp1[ai] ^ c1[ai];
    assign {bus.key_hs_2nd, bus.pat_2nd, bus.ccode_2nd} = exp2[ai] ^ c2[ai];

    // Reader: advances on increment, raises its stop flag after the last address.
    always @(posedge clock) begin
      if (rdr_clr) begin
        adr <= '0;
        dn  <= 1'b0;
      end else begin
        if (force_done) dn <= 1'b1;
        if (bus.increment) begin
          if (&adr) dn <= 1'b1;
          else      adr <= adr + 1'b1;
        end
      end
    end

    ev_t q[$];
    bit  seen_done = 1'b0;
    int  abort_off = 0;

    task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
        n_mis++;
        $display("FAIL inst%0d %s: got %0d, expected %0d (t=%0t)", k, nm, act, req, $time);
      end
    endtask

    function automatic bit vec_bad(input int a);
      return (c1[a] != 0) || ((C2 != 0) && (c2[a] != 0));
    endfunction

    always @(negedge reset_n) begin
      #1;
      chk("reset flags", int'({bus.increment, bus.busy, bus.done, bus.pass, bus.first_err_vld}), 0);
      chk("reset counts", int'(bus.vec_cnt) + int'(bus.err_cnt) + int'(bus.first_err_adr), 0);
      if (!mid_reset) chk("events outstanding", q.size(), 0);
      q.delete();
      seen_done = 1'b0;
    end

    always @(negedge clock) begin : mon
      ev_t e;
      int  s, errs, fa, nv, endc, chkc;
      bit  fv;
      if (reset_n) begin
        if (bus.increment) begin
          if (q.size() == 0 || q[0].is_done) begin
            chk("unexpected increment", 1, 0);
          end else begin
            e = q.pop_front();
            chk("increment cycle", cyc, e.cyc);
            chk("vec_cnt at check", int'(bus.vec_cnt), e.vec);
            chk("err_cnt at check", int'(bus.err_cnt), e.err);
            chk("busy at check", int'(bus.busy), 1);
          end
        end
        if (bus.done && !seen_done) begin
          seen_done = 1'b1;
          if (q.size() == 0 || !q[0].is_done) begin
            chk("unexpected done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done cycle", cyc, e.cyc);
            chk("final vec_cnt", int'(bus.vec_cnt), e.vec);
            chk("final err_cnt", int'(bus.err_cnt), e.err);
            chk("first_err_vld", int'(bus.first_err_vld), int'(e.fvld));
            chk("first_err_adr", int'(bus.first_err_adr), e.fadr);
            chk("pass", int'(bus.pass), int'(e.pass));
            chk("busy at done", int'(bus.busy), 0);
          end
        end else if (seen_done && !bus.done) begin
          chk("done sticky", int'(bus.done), 1);
        end

        if (start) begin
          s = cyc;
          if (dn) begin
            q.push_back('{1'b1, s + 1, 0, 0, 0, 1'b0, 1'b1});
          end else begin
            errs = 0; fa = 0; fv = 1'b0; nv = 0;
            endc = s + NV * (LAT + 1) + 1;
            for (int a = 0; a < NV; a++) begin
              chkc = s + (a + 1) * (LAT + 1);
              if (abort_off != 0 && s + abort_off < chkc) begin
                endc = s + abort_off + 1;
                break;
              end
              q.push_back('{1'b0, chkc, a, (errs > SAT) ? SAT : errs, 0, 1'b0, 1'b0});
              nv++;
              if (vec_bad(a)) begin
                errs++;
                if (!fv) begin fa = a; fv = 1'b1; end
              end
            end
            q.push_back('{1'b1, endc, nv, (errs > SAT) ? SAT : errs, fa, fv, errs == 0});
          end
        end
      end
    end
  end

  task automatic set_abort(input int v);
    g_inst[0].abort_off = v;
    g_inst[1].abort_off = v;
    g_inst[2].abort_off = v;
    g_inst[3].abort_off = v;
  endtask

  task automatic do_reset(input bit mid);
    @(posedge clock);
    #2;
    mid_reset  = mid;
    reset_n    = 1'b0;
    rdr_clr    = 1'b1;
    force_done = 1'b0;
    set_abort(0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1 rdr_clr = 1'b0;
  endtask

  // 0 clean, 1 pat_1st^1 at 2/5, 2 ccode_2nd bad everywhere, 3 all 1st bad, 4 random
  task automatic fill(input int mode);
    for (int a = 0; a < 8; a++) begin
      exp1[a] = 24'($urandom());
      exp2[a] = 24'($urandom());
      c1[a]   = '0;
      c2[a]   = '0;
      case (mode)
        1: if (a == 2 || a == 5) c1[a] = 24'h001000;
        2: c2[a] = 24'(1 << $urandom_range(0, 11));
        3: c1[a] = 24'(1 << $urandom_range(0, 23));
        4: begin
          if ($urandom_range(0, 1) == 1) c1[a] = 24'(1 << $urandom_range(0, 23));
          if ($urandom_range(0, 1) == 1) c2[a] = 24'(1 << $urandom_range(0, 23));
        end
        default: ;
      endcase
    end
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 5; m++) begin
      do_reset(0);
      fill(m);
      pulse_start();
      repeat (50) @(posedge clock);
    end
    repeat (3) begin
      do_reset(0);
      fill(4);
      pulse_start();
      repeat (50) @(posedge clock);
    end

    // reader already stopped when start arrives
    do_reset(0);
    fill(0);
    @(posedge clock);
    #1 force_done = 1'b1;
    pulse_start();
    repeat (10) @(posedge clock);

    // reader stop flag rises mid-run, during a wait window
    do_reset(0);
    fill(4);
    set_abort(17);
    pulse_start();
    repeat (15) @(posedge clock);
    #1 force_done = 1'b1;
    repeat (30) @(posedge clock);

    // reset mid-run after three vectors, then a clean restart
    do_reset(0);
    fill(1);
    pulse_start();
    repeat (15) @(posedge clock);
    do_reset(1);
    pulse_start();
    repeat (50) @(posedge clock);

    do_reset(0);
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/pf_result_checker.md
Name: pf_result_checker

Overview:
- Downstream consumer of the pattern-finder test-vector reader.
- Paces the reader through its ROM by pulsing `increment`, waits a fixed pattern-finder pipeline latency, then compares the finder's 1st/2nd CLCT results against the reader's expected values.
- Accumulates vector and mismatch counts and latches the first failing address.
- Provides the pass/fail summary for the pattern-finder simulation bench and on-chip self-test.

Parameters:
- MXADRB, 10, reader address width; ADR_MAX = 2**MXADRB vectors.
- PF_LATENCY, 4, clocks from reader address change to valid finder outputs; legal range 1..15.
- MXERRB, 16, error counter width.
- CHECK_2ND, 1, when 0 the 2nd-CLCT fields are excluded from comparison.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a check run.
- rd_adr  in  MXADRB  reader current address.
- rd_done  in  1  reader stopped flag.
- increment  out  1  one-cycle advance pulse to reader.
- key_hs_expect_1st / key_hs_expect_2nd  in  8  expected key half-strip.
- pat_expect_1st / pat_expect_2nd  in  4  expected pattern id.
- ccode_expect_1st / ccode_expect_2nd  in  12  expected comparator code.
- key_hs_1st / key_hs_2nd  in  8  finder key half-strip.
- pat_1st / pat_2nd  in  4  finder pattern id.
- ccode_1st / ccode_2nd  in  12  finder comparator code.
- busy  out  1  run in progress.
- done  out  1  run complete (sticky).
- pass  out  1  done and zero errors.
- vec_cnt  out  MXADRB+1  vectors compared.
- err_cnt  out  MXERRB  mismatching vectors, saturating.
- first_err_adr  out  MXADRB  address of first mismatch.
- first_err_vld  out  1  first_err_adr valid.

Behaviour:
- All outputs are registered.
- Reset (async assert, any time including mid-run): state IDLE; all counters and flags zero, including increment, busy, done, pass, vec_cnt, err_cnt, first_err_adr and first_err_vld.
- State machine:
  - IDLE: on start=1:
    - clear vec_cnt, err_cnt, first_err_*.
    - If rd_done=1, go to DONE with vec_cnt=0.
    - Otherwise go to WAIT with wait counter = PF_LATENCY; busy=1.
  - WAIT: counter decrements each clock. WAIT lasts exactly PF_LATENCY cycles, then goes to CHECK.
  - CHECK: single cycle.
    - Compare; vec_cnt += 1.
    - Mismatch = any inequality in key_hs, pat or ccode for 1st, OR (CHECK_2ND=1 AND any inequality in 2nd fields).
    - On mismatch: err_cnt += 1, holding at all-ones.
    - On mismatch with first_err_vld=0: first_err_adr=rd_adr, first_err_vld=1.
    - increment=1 for this cycle only.
    - If rd_adr == ADR_MAX-1, go to DONE; otherwise go to WAIT reloaded with PF_LATENCY.
  - DONE: busy=0, done=1, pass=(err_cnt==0). Holds until reset.
- Timing: start sampled at cycle s gives the first CHECK at s+PF_LATENCY+1. An increment at cycle t gives the reader address change at t+1 and the next CHECK at t+PF_LATENCY+1. A full run takes ADR_MAX*(PF_LATENCY+1) cycles after start.
- The final increment at address ADR_MAX-1 is still issued, so the reader sets its stop flag.
- start is ignored in WAIT, CHECK and DONE.
- rd_done rising while busy aborts the run: go to DONE at the next edge with counts preserved, no further increment, no comparison that cycle.
- vec_cnt reaches exactly ADR_MAX on a normal run; the width is sized so it cannot wrap.
- increment is never asserted outside CHECK, never in two consecutive cycles, and never when rd_done=1.

Test Plan:
- Reset then start, MXADRB=3, PF_LATENCY=4, finder outputs tied to expected: increment pulses at cycles s+5, s+10, …, s+40 (8 pulses); done at s+41; vec_cnt=8, err_cnt=0, pass=1, first_err_vld=0.
- Same run with pat_1st forced to expected^1 only at addresses 2 and 5: err_cnt=2, first_err_adr=2, first_err_vld=1, pass=0.
- CHECK_2ND=0 with ccode_2nd corrupted on every vector: err_cnt=0, pass=1. Same stimulus with CHECK_2ND=1: err_cnt=8.
- MXERRB=2, all 8 vectors mismatching: err_cnt saturates at 3, first_err_adr=0.
- Start with rd_done=1: no increment ever, done=1 next cycle, vec_cnt=0, pass=1.
- reset_n low during WAIT after 3 vectors: outputs zero immediately (asynchronous), state IDLE, increment=0. A subsequent start restarts the counts from zero.
